alarm_sequencer: RTL

Control FSM for the clock's alarm function. It owns the alarm set-point registers, handles the mode/increment/stop buttons for setting the alarm, compares the running time against the set-point, and sequences ringing, timeout, dismiss and snooze. It sits between the button front-end, which supplies synchronous debounced levels, and the beeper/display, in the same clock domain as the timekeeping counters.

---
 rtl/alarm_sequencer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/alarm_sequencer.sv
// Alarm control: owns the set-point, decodes button presses, detects the time match and
// sequences ringing, timeout and dismiss. Define ALARM_SNOOZE_EN to add the SNOOZE state.
module alarm_sequencer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic        stop_btn,
  input  logic [13:0] hour,
  input  logic [13:0] minute,
  output logic [13:0] alarm_hour,
  output logic [13:0] alarm_minute,
  output logic        armed,
  output logic [1:0]  setting,
  output logic        ringing,
  output logic        beep
);

  localparam logic [15:0] RING_LIM = 16'(RING_SECS);

  if (RING_SECS < 1 || RING_SECS > 65535) begin : g_bad_ring_secs
    $error("RING_SECS must be in 1..65535");
  end
  if (SNOOZE_SECS < 1 || SNOOZE_SECS > 65535) begin : g_bad_snooze_secs
    $error("SNOOZE_SECS must be in 1..65535");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_HR,
    ST_SET_MIN,
    ST_RING
`ifdef ALARM_SNOOZE_EN
    , ST_SNOOZE
`endif
  } state_t;

  state_t      r_state;
  logic [13:0] r_alarm_hour;
  logic [13:0] r_alarm_minute;
  logic        r_armed;
  logic [1:0]  r_setting;
  logic        r_ringing;
  logic        r_beep;
  logic        r_fired;
  logic [15:0] r_ring_cnt;
  logic        r_mode_q;
  logic        r_inc_q;
  logic        r_stop_q;

  state_t      w_state_next;
  logic [13:0] w_alarm_hour_next;
  logic [13:0] w_alarm_minute_next;
  logic        w_armed_next;
  logic [1:0]  w_setting_next;
  logic        w_ringing_next;
  logic        w_beep_next;
  logic        w_fired_next;
  logic [15:0] w_ring_cnt_next;
  logic [15:0] w_ring_inc;
  logic        w_enter_ring;
  logic        w_match;
  logic        w_press_mode;
  logic        w_press_inc;
  logic        w_press_stop;
  logic        w_act_stop;
  logic        w_act_mode;
  logic        w_act_inc;

`ifdef ALARM_SNOOZE_EN
  localparam logic [15:0] SNOOZE_LIM = 16'(SNOOZE_SECS);
  logic [15:0] r_snz_cnt;
  logic [15:0] w_snz_cnt_next;
  logic [15:0] w_snz_inc;
  assign w_snz_inc = r_snz_cnt + 16'd1;
`endif

  // Only one press acts per edge: stop beats mode beats inc.
  assign w_press_mode = mode_btn & ~r_mode_q;
  assign w_press_inc  = inc_btn  & ~r_inc_q;
  assign w_press_stop = stop_btn & ~r_stop_q;
  assign w_act_stop   = w_press_stop;
  assign w_act_mode   = w_press_mode & ~w_press_stop;
  assign w_act_inc    = w_press_inc  & ~w_press_stop & ~w_press_mode;

  assign w_match    = (hour == r_alarm_hour) && (minute == r_alarm_minute);
  assign w_ring_inc = r_ring_cnt + 16'd1;

  always_comb begin
    w_state_next        = r_state;
    w_alarm_hour_next   = r_alarm_hour;
    w_alarm_minute_next = r_alarm_minute;
    w_armed_next        = r_armed;
    w_beep_next         = r_beep;
    w_ring_cnt_next     = r_ring_cnt;
    w_enter_ring        = 1'b0;
`ifdef ALARM_SNOOZE_EN
    w_snz_cnt_next      = r_snz_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_act_stop) begin
          w_armed_next = ~r_armed;
        end else if (w_act_mode) begin
          w_state_next = ST_SET_HR;
        end else if (r_armed && w_match && !r_fired) begin
          w_state_next = ST_RING;
          w_enter_ring = 1'b1;
        end
      end
      ST_SET_HR: begin
        if (w_act_stop) begin
          w_state_next = ST_IDLE;
        end else if (w_act_mode) begin
          w_state_next = ST_SET_MIN;
        end else if (w_act_inc) begin
          w_alarm_hour_next = (r_alarm_hour == 14'd23) ? 14'd0 : r_alarm_hour + 14'd1;
        end
      end
      ST_SET_MIN: begin
        if (w_act_stop) begin
          w_state_next = ST_IDLE;
        end else if (w_act_mode) begin
          w_state_next = ST_IDLE;
          w_armed_next = 1'b1;
        end else if (w_act_inc) begin
          w_alarm_minute_next = (r_alarm_minute == 14'd59) ? 14'd0 : r_alarm_minute + 14'd1;
        end
      end
      ST_RING: begin
        if (w_act_stop) begin
          w_state_next = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (w_act_inc) begin
          w_state_next   = ST_SNOOZE;
          w_snz_cnt_next = 16'd0;
`endif
        end else if (tick_1hz) begin
          w_ring_cnt_next = w_ring_inc;
          w_beep_next     = ~r_beep;
          if (w_ring_inc == RING_LIM) begin
            w_state_next = ST_IDLE;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (w_act_stop) begin
          w_state_next = ST_IDLE;
        end else if (tick_1hz) begin
          w_snz_cnt_next = w_snz_inc;
          if (w_snz_inc == SNOOZE_LIM) begin
            w_state_next = ST_RING;
            w_enter_ring = 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Beep is only ever driven in RING and always restarts high on entry.
    if (w_enter_ring) begin
      w_ring_cnt_next = 16'd0;
      w_beep_next     = 1'b1;
    end else if (w_state_next != ST_RING) begin
      w_beep_next = 1'b0;
    end

    // Once rung, stay quiet until the time moves off the set-point.
    if (w_enter_ring) begin
      w_fired_next = 1'b1;
    end else if (!w_match) begin
      w_fired_next = 1'b0;
    end else begin
      w_fired_next = r_fired;
    end

    w_ringing_next = (w_state_next == ST_RING);
    case (w_state_next)
      ST_SET_HR:  w_setting_next = 2'b01;
      ST_SET_MIN: w_setting_next = 2'b10;
      default:    w_setting_next = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_alarm_hour   <= 14'd0;
      r_alarm_minute <= 14'd0;
      r_armed        <= 1'b0;
      r_setting      <= 2'b00;
      r_ringing      <= 1'b0;
      r_beep         <= 1'b0;
      r_fired        <= 1'b0;
      r_ring_cnt     <= 16'd0;
      r_mode_q       <= 1'b0;
      r_inc_q        <= 1'b0;
      r_stop_q       <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      r_snz_cnt      <= 16'd0;
`endif
    end else begin
      r_state        <= w_state_next;
      r_alarm_hour   <= w_alarm_hour_next;
      r_alarm_minute <= w_alarm_minute_next;
      r_armed        <= w_armed_next;
      r_setting      <= w_setting_next;
      r_ringing      <= w_ringing_next;
      r_beep         <= w_beep_next;
      r_fired        <= w_fired_next;
      r_ring_cnt     <= w_ring_cnt_next;
      r_mode_q       <= mode_btn;
      r_inc_q        <= inc_btn;
      r_stop_q       <= stop_btn;
`ifdef ALARM_SNOOZE_EN
      r_snz_cnt      <= w_snz_cnt_next;
`endif
    end
  end

  assign alarm_hour   = r_alarm_hour;
  assign alarm_minute = r_alarm_minute;
  assign armed        = r_armed;
  assign setting      = r_setting;
  assign ringing      = r_ringing;
  assign beep         = r_beep;

endmodule
